// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM states, instruction geometry and opcode flag positions.
// The argument controller and decoder import the flag bit positions from here.
package fetch_pkg;

  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned INSTR_BYTES = 4;

  localparam int unsigned IMM1_BIT = 7;
  localparam int unsigned IMM2_BIT = 6;
  localparam int unsigned COND_BIT = 5;

  typedef enum logic [2:0] {
    F0    = 3'd0,
    F1    = 3'd1,
    F2    = 3'd2,
    F3    = 3'd3,
    F4    = 3'd4,
    VALID = 3'd5
  } fetch_state_e;

endpackage : fetch_pkg

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: byte-wide program ROM port plus the instruction handshake to execute.
interface instruction_fetch_if;
  import fetch_pkg::*;

  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  logic [DATA_W-1:0] opcode1;
  logic [DATA_W-1:0] opcode2;
  logic [DATA_W-1:0] opcode3;
  logic [DATA_W-1:0] opcode4;
  logic              imm1;
  logic              imm2;
  logic              is_cond;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] next_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              jump_taken;

  // Fetch stage side
  modport master (
    output rom_addr,
    input  rom_data,
    output opcode1, opcode2, opcode3, opcode4,
    output imm1, imm2, is_cond,
    output pc, next_pc,
    output instr_valid,
    input  instr_ready,
    input  jump_taken
  );

  // ROM plus downstream consumer side
  modport slave (
    input  rom_addr,
    output rom_data,
    input  opcode1, opcode2, opcode3, opcode4,
    input  imm1, imm2, is_cond,
    input  pc, next_pc,
    input  instr_valid,
    output instr_ready,
    output jump_taken
  );

endinterface : instruction_fetch_if

// File: rtl/instruction_fetch.sv
// Instruction fetch: reads four ROM bytes per instruction, presents them under valid/ready,
// and owns the program counter (sequential +4 or jump load from the fourth byte on accept).
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input logic                 clk,
  input logic                 rst,
  instruction_fetch_if.master bus
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;

  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_op [INSTR_BYTES];

  logic [ADDR_W-1:0] w_rom_addr;
  logic              w_lat_en;
  logic [1:0]        w_lat_idx;
  logic              w_instr_valid;
  logic              w_accept;
  logic [ADDR_W-1:0] w_pc_seq;

  assign w_accept = w_instr_valid & bus.instr_ready;
  assign w_pc_seq = r_pc + ADDR_W'(INSTR_BYTES);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= F0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: fixed byte sequence, then hold until accepted
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      F0:      w_state_nxt = F1;
      F1:      w_state_nxt = F2;
      F2:      w_state_nxt = F3;
      F3:      w_state_nxt = F4;
      F4:      w_state_nxt = VALID;
      VALID:   w_state_nxt = bus.instr_ready ? F0 : VALID;
      default: w_state_nxt = F0;
    endcase
  end

  // Output decode: ROM byte address, which byte lands this cycle, and valid
  always_comb begin
    w_rom_addr    = r_pc;
    w_lat_en      = 1'b0;
    w_lat_idx     = 2'd0;
    w_instr_valid = 1'b0;
    unique case (r_state)
      F0: w_rom_addr = r_pc;
      F1: begin
        w_rom_addr = r_pc + 8'd1;
        w_lat_en   = 1'b1;
        w_lat_idx  = 2'd0;
      end
      F2: begin
        w_rom_addr = r_pc + 8'd2;
        w_lat_en   = 1'b1;
        w_lat_idx  = 2'd1;
      end
      F3: begin
        w_rom_addr = r_pc + 8'd3;
        w_lat_en   = 1'b1;
        w_lat_idx  = 2'd2;
      end
      F4: begin
        w_lat_en  = 1'b1;
        w_lat_idx = 2'd3;
      end
      VALID:   w_instr_valid = 1'b1;
      default: w_rom_addr = r_pc;
    endcase
  end

  // Program counter: reset beats any accept in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (w_accept) begin
      r_pc <= bus.jump_taken ? r_op[3] : w_pc_seq;
    end
  end

  // Instruction byte latches; the ROM returns the byte requested one cycle earlier
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(INSTR_BYTES); i++) begin
        r_op[i] <= '0;
      end
    end else if (w_lat_en) begin
      r_op[w_lat_idx] <= bus.rom_data;
    end
  end

  assign bus.rom_addr    = w_rom_addr;
  assign bus.opcode1     = r_op[0];
  assign bus.opcode2     = r_op[1];
  assign bus.opcode3     = r_op[2];
  assign bus.opcode4     = r_op[3];
  assign bus.imm1        = r_op[0][IMM1_BIT];
  assign bus.imm2        = r_op[0][IMM2_BIT];
  assign bus.is_cond     = r_op[0][COND_BIT];
  assign bus.pc          = r_pc;
  assign bus.next_pc     = w_pc_seq;
  assign bus.instr_valid = w_instr_valid;

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: 1-cycle synchronous ROM model, hand-computed expectations.
module tb_instruction_fetch;

  logic clk;
  logic rst;
  logic [7:0] rom [256];

  int unsigned n_vec;
  int unsigned n_miss;

  instruction_fetch_if bus ();

  instruction_fetch #(.RESET_PC(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data for the address driven this cycle appears next cycle
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check_instr(input string tag,
                             input logic [7:0] e1, input logic [7:0] e2,
                             input logic [7:0] e3, input logic [7:0] e4,
                             input logic ei1, input logic ei2, input logic ec,
                             input logic [7:0] epc, input logic [7:0] enpc);
    check({tag, ".valid"},   16'(bus.instr_valid), 16'(1'b1));
    check({tag, ".op1"},     16'(bus.opcode1), 16'(e1));
    check({tag, ".op2"},     16'(bus.opcode2), 16'(e2));
    check({tag, ".op3"},     16'(bus.opcode3), 16'(e3));
    check({tag, ".op4"},     16'(bus.opcode4), 16'(e4));
    check({tag, ".imm1"},    16'(bus.imm1), 16'(ei1));
    check({tag, ".imm2"},    16'(bus.imm2), 16'(ei2));
    check({tag, ".is_cond"}, 16'(bus.is_cond), 16'(ec));
    check({tag, ".pc"},      16'(bus.pc), 16'(epc));
    check({tag, ".next_pc"}, 16'(bus.next_pc), 16'(enpc));
    check({tag, ".rom_addr"}, 16'(bus.rom_addr), 16'(epc));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".valid"},    16'(bus.instr_valid), 16'(1'b0));
    check({tag, ".rom_addr"}, 16'(bus.rom_addr), 16'h00);
    check({tag, ".pc"},       16'(bus.pc), 16'h00);
    check({tag, ".next_pc"},  16'(bus.next_pc), 16'h04);
    check({tag, ".ops"}, 16'({bus.opcode1, bus.opcode2} | {bus.opcode3, bus.opcode4}), 16'h0000);
    check({tag, ".flags"}, 16'({bus.imm1, bus.imm2, bus.is_cond}), 16'h0);
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    for (int a = 0; a < 256; a++) rom[a] = 8'h00;
    rom[8'h00] = 8'hC1; rom[8'h01] = 8'h05; rom[8'h02] = 8'h07; rom[8'h03] = 8'h02;
    rom[8'h04] = 8'h20; rom[8'h05] = 8'h11; rom[8'h06] = 8'h22; rom[8'h07] = 8'h40;
    rom[8'h08] = 8'h01; rom[8'h09] = 8'h02; rom[8'h0A] = 8'h03; rom[8'h0B] = 8'h04;
    rom[8'h0C] = 8'h05; rom[8'h0D] = 8'h06; rom[8'h0E] = 8'h07; rom[8'h0F] = 8'h08;
    rom[8'h10] = 8'h20; rom[8'h11] = 8'h00; rom[8'h12] = 8'h00; rom[8'h13] = 8'hFE;
    rom[8'h40] = 8'h20; rom[8'h41] = 8'h00; rom[8'h42] = 8'h00; rom[8'h43] = 8'hFC;
    rom[8'hFC] = 8'hA0; rom[8'hFD] = 8'h01; rom[8'hFE] = 8'h12; rom[8'hFF] = 8'h34;

    rst             = 1'b1;
    bus.instr_ready = 1'b0;
    bus.jump_taken  = 1'b0;
    repeat (3) step();
    check_cleared("reset");

    // First fetch from 00, cycle 0 is the first cycle after release
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("f00.addr%0d", c), 16'(bus.rom_addr), 16'(c));
      check($sformatf("f00.nv%0d", c), 16'(bus.instr_valid), 16'(1'b0));
      step();
    end
    step();
    check_instr("i00", 8'hC1, 8'h05, 8'h07, 8'h02, 1'b1, 1'b1, 1'b0, 8'h00, 8'h04);

    // Backpressure: everything frozen while VALID waits
    for (int c = 0; c < 10; c++) begin
      step();
      check($sformatf("hold%0d.valid", c), 16'(bus.instr_valid), 16'(1'b1));
      check($sformatf("hold%0d.addr", c), 16'(bus.rom_addr), 16'h00);
      check($sformatf("hold%0d.op", c), 16'({bus.opcode1, bus.opcode4}), 16'hC102);
      check($sformatf("hold%0d.pc", c), 16'({bus.pc, bus.next_pc}), 16'h0004);
    end
    bus.jump_taken  = 1'b1;
    bus.instr_ready = 1'b0;
    step();
    bus.jump_taken  = 1'b0;
    check("nojump_wo_accept.pc", 16'(bus.pc), 16'h00);
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    check("acc00.addr", 16'(bus.rom_addr), 16'h04);
    check("acc00.valid", 16'(bus.instr_valid), 16'(1'b0));
    check("acc00.pc", 16'(bus.pc), 16'h04);

    // Conditional instruction at 04, jump taken to 40
    repeat (5) step();
    check_instr("i04", 8'h20, 8'h11, 8'h22, 8'h40, 1'b0, 1'b0, 1'b1, 8'h04, 8'h08);
    bus.instr_ready = 1'b1;
    bus.jump_taken  = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    bus.jump_taken  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("f40.addr%0d", c), 16'(bus.rom_addr), 16'(8'h40 + c));
      step();
    end
    step();
    check_instr("i40", 8'h20, 8'h00, 8'h00, 8'hFC, 1'b0, 1'b0, 1'b1, 8'h40, 8'h44);

    // Jump to FC, then accept sequentially: pc wraps to 00
    bus.instr_ready = 1'b1;
    bus.jump_taken  = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    bus.jump_taken  = 1'b0;
    repeat (5) step();
    check_instr("iFC", 8'hA0, 8'h01, 8'h12, 8'h34, 1'b1, 1'b0, 1'b1, 8'hFC, 8'h00);
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    check("wrapFC.pc", 16'(bus.pc), 16'h00);
    check("wrapFC.addr", 16'(bus.rom_addr), 16'h00);

    // Reset pulse in F2 discards partial fetch
    step();
    step();
    check("f2.op1", 16'(bus.opcode1), 16'hC1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_cleared("rstF2");

    // Reset in VALID with accept and jump asserted: reset wins
    repeat (5) step();
    check("preV.valid", 16'(bus.instr_valid), 16'(1'b1));
    check("preV.op4", 16'(bus.opcode4), 16'h02);
    rst             = 1'b1;
    bus.instr_ready = 1'b1;
    bus.jump_taken  = 1'b1;
    step();
    rst             = 1'b0;
    bus.instr_ready = 1'b0;
    bus.jump_taken  = 1'b0;
    check_cleared("rstV");

    // Throughput with ready held high: one valid pulse every 6 cycles
    bus.instr_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      check($sformatf("tp%0d.valid", c), 16'(bus.instr_valid), 16'((c % 6) == 5));
      if ((c % 6) == 5) begin
        check($sformatf("tp%0d.pc", c), 16'(bus.pc), 16'(4 * (c / 6)));
      end
      if (c == 29) bus.jump_taken = 1'b1;
      step();
    end
    bus.instr_ready = 1'b0;
    bus.jump_taken  = 1'b0;

    // Jump to FE: fetch addresses wrap within the instruction
    for (int c = 0; c < 4; c++) begin
      check($sformatf("fFE.addr%0d", c), 16'(bus.rom_addr), 16'(8'(8'hFE + c)));
      step();
    end
    step();
    check_instr("iFE", 8'h12, 8'h34, 8'hC1, 8'h05, 1'b0, 1'b0, 1'b0, 8'hFE, 8'h02);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_instruction_fetch

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the model computer: reads each 4-byte instruction (opcode, arg1, arg2, arg3/target) one byte per cycle from the byte-wide synchronous program ROM. It presents the assembled instruction, immediate flags and program counter to the argument controller / execute stage under a valid/ready handshake. It also owns the program counter: sequential advance by 4, or load from byte 4 on a taken jump.

## Interface
Parameters:
- `RESET_PC`, 8'h00, PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rom_addr`  out  8  program ROM byte address.
- `rom_data`  in  8  ROM read data; valid the cycle after `rom_addr` is driven (1-cycle synchronous ROM).
- `opcode1`..`opcode4`  out  8 each  instruction bytes 0..3 (opcode, arg1, arg2, arg3/jump target).
- `imm1`  out  1  `opcode1[7]`: arg1 is immediate.
- `imm2`  out  1  `opcode1[6]`: arg2 is immediate.
- `is_cond`  out  1  `opcode1[5]`: conditional/jump instruction.
- `pc`  out  8  address of `opcode1` of the presented instruction (counter value `cnt` downstream).
- `next_pc`  out  8  `pc + 4` mod 256 (return/write-back address).
- `instr_valid`  out  1  instruction bytes stable and presentable.
- `instr_ready`  in  1  downstream accepts the instruction.
- `jump_taken`  in  1  sampled only on accept; 1 loads `pc <= opcode4`.

## Operation
- States: F0, F1, F2, F3, F4, VALID. A 3-bit state register encodes them.
- In Fk (k=0..3), `rom_addr = pc + k` (8-bit wrap). In F4 and VALID, `rom_addr = pc`.
- In F1..F4, `rom_data` latches into `opcode1`..`opcode4` respectively; returned bytes are never lost.
- Transitions: F0→F1→F2→F3→F4→VALID unconditionally. VALID holds until `instr_valid & instr_ready`, then → F0.
- On accept: `pc <= jump_taken ? opcode4 : pc + 4` (mod 256). `jump_taken` is ignored outside accept. This block does no condition evaluation; `is_cond` is informational.
- `instr_valid = (state == VALID)`, registered-state derived, no combinational path from `instr_ready`.
- While VALID, `opcode1..4`, `imm*`, `is_cond`, `pc`, `next_pc` are held stable. During F0..F4 opcode registers update in place, and consumers must not use them.
- `imm1`, `imm2`, `is_cond`, `next_pc` are combinational from registered `opcode1` / `pc`.
- Reset values: state F0, `pc = RESET_PC`, `opcode1..4 = 0`, so `imm1 = imm2 = is_cond = 0`, `instr_valid = 0`, `rom_addr = RESET_PC`, `next_pc = RESET_PC + 4`.
- Reset mid-operation (any state, including VALID with `instr_ready` high) wins. The instruction is discarded, no PC update occurs, and fetch restarts at `RESET_PC`.

## Timing
- Fetch latency: first cycle after reset release is F0. `instr_valid` is high in cycle 5 (cycles counted from 0).
- Throughput: with `instr_ready` tied high, one instruction per 6 cycles. The accept cycle is VALID and the next cycle is F0 at the new PC.
- Wrap-around: byte addresses wrap within a fetch (pc=8'hFE fetches FE, FF, 00, 01). `pc + 4` wraps (FC→00).
- Backpressure: unbounded VALID hold. No ROM address change and no output change while waiting.

## Structure
- Shared package `fetch_pkg` contains:
  - state enum (F0..F4, VALID);
  - `INSTR_BYTES = 4`;
  - `IMM1_BIT = 7`, `IMM2_BIT = 6`, `COND_BIT = 5`.
  - The argument controller and decoder import the flag positions from it.
- Single module, no sub-modules. PC, byte latches and FSM are small enough to share one always block per register group.

## Test plan
- Reset release, ROM[0..3]=C1,05,07,02 → `rom_addr` 00,01,02,03 in cycles 0–3. In cycle 5: `instr_valid=1`, `opcode1..4`=C1,05,07,02, `imm1=1`, `imm2=1`, `is_cond=0`, `pc=00`, `next_pc=04`.
- `instr_ready=0` for 10 cycles in VALID → all outputs and `rom_addr` constant. Assert `instr_ready` → next cycle F0, `rom_addr=04`, `instr_valid=0`.
- Accept with `jump_taken=1`, `opcode1=20`, `opcode4=40` → `is_cond=1` during VALID. Next fetch drives 40,41,42,43, then `pc=40`.
- Wrap cases: `pc=FC` accepted without jump → `pc=00`. Jump to FE → `rom_addr` FE,FF,00,01, `next_pc=02`.
- `rst` pulsed in F2, and separately in VALID with `instr_ready=1, jump_taken=1` → next cycle F0, `rom_addr=RESET_PC`, `opcode1..4=0`, no jump applied.
- `instr_ready` held high over 5 instructions → `instr_valid` pulses exactly every 6 cycles, one cycle wide, with `pc` 00,04,08,0C,10.
